// File: rtl/uart_rx_sequencer.sv
// Frame controller behind the oversampling synchronizer: start/data/(parity)/stop sequencing
// into a first-word-fall-through byte FIFO. Define UART_RX_PARITY_EN to enable the parity bit.
module uart_rx_sequencer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud,
    input  logic                 rx_bit,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic [7:0]           err_count
);

    localparam int unsigned CntW  = $clog2(DATA_BITS);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StData, StStop, StBreak} state_e;
`endif

    state_e               state_q, state_d;
    logic                 baud_q;
    logic                 stb;
    logic [CntW-1:0]      bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 last_bit;

    logic                 push;
    logic                 pop;
    logic                 wr_en;
    logic                 full;
    logic                 empty;
    logic                 frame_err_d;
    logic                 parity_err_d;
    logic                 overrun_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;

    // baud_q resets high so a baud already high at release is not taken as an edge
    assign stb      = baud & ~baud_q;
    assign last_bit = (bit_cnt_q == CntW'(DATA_BITS - 1));

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        if (stb) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_bit) state_d = StData;
                end
                StData: begin
`ifdef UART_RX_PARITY_EN
                    if (last_bit) state_d = StParity;
`else
                    if (last_bit) state_d = StStop;
`endif
                end
`ifdef UART_RX_PARITY_EN
                StParity: state_d = StStop;
`endif
                StStop: state_d = rx_bit ? StIdle : StBreak;
                StBreak: begin
                    if (rx_bit) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_ok_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_ok_q <= 1'b1;
        end else if (stb && state_q == StParity) begin
            parity_ok_q <= ((^shreg_q) ^ rx_bit) == PARITY_ODD;
        end
    end
`endif

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        push         = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (stb && state_q == StStop) begin
            if (!rx_bit) begin
                frame_err_d = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
                push         = parity_ok_q;
                parity_err_d = !parity_ok_q;
`else
                push         = 1'b1;
`endif
            end
        end
    end

    // ---------------------------------------------------------------- frame datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q    <= 1'b1;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            baud_q <= baud;
            if (stb && state_q == StIdle) begin
                bit_cnt_q <= '0;
            end
            if (stb && state_q == StData) begin
                shreg_q   <= {rx_bit, shreg_q[DATA_BITS-1:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- receive FIFO
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign m_valid   = !empty;
    assign pop       = m_valid && m_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en     = push && (!full || pop);
    assign overrun_d = push && full && !pop;
    assign m_data    = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
            if ((frame_err_d || parity_err_d) && err_count != 8'hFF) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: directed frame table, multi-cycle corner
// sequences and randomized traffic against a frame-level FIFO model.
`timescale 1ns/1ps
module tb_uart_rx_sequencer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam bit POD   = 1'b0;

    typedef enum int {TagNone, TagGood, TagFerr, TagPerr} tag_e;
    typedef struct {
        logic       b;
        tag_e       tag;
        logic [7:0] data;
    } lbit_t;
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         n_low;
        int         exp_pops;
        logic [7:0] exp_byte;
        int         exp_ferr;
        int         exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baud = 1'b0;
    logic          rx_bit = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;
    logic [7:0]    err_count;

    uart_rx_sequencer #(
        .DATA_BITS (DW),
        .FIFO_DEPTH(DEPTH),
        .PARITY_ODD(POD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud      (baud),
        .rx_bit    (rx_bit),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    lbit_t      line_q[$];
    logic [7:0] fifo_m[$];
    logic [7:0] popped[$];
    lbit_t      cur;
    int         exp_cnt;
    logic       exp_ferr, exp_perr, exp_ovr;
    int         phase;
    int         ready_mode;
    int         seen_ferr, seen_perr, seen_ovr;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        lbit_t e;
        e.b = b;
        e.tag = TagNone;
        e.data = 8'h00;
        line_q.push_back(e);
    endtask

    // Start, LSB-first data, optional parity, stop; a failed stop is followed by n_low
    // extra low bits and one high bit so the line returns to idle.
    task automatic queue_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                               input int n_low);
        lbit_t e;
        push_bit(1'b0);
        for (int i = 0; i < DW; i++) push_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        push_bit((^d) ^ POD ^ bad_par);
        e.tag = !stop ? TagFerr : (bad_par ? TagPerr : TagGood);
`else
        e.tag = stop ? TagGood : TagFerr;
        if (bad_par) e.tag = e.tag;
`endif
        e.b = stop;
        e.data = d;
        line_q.push_back(e);
        if (!stop) begin
            repeat (n_low) push_bit(1'b0);
            push_bit(1'b1);
        end
    endtask

    // One clock: compare outputs with the model, drive the next inputs, advance the model.
    task automatic step();
        logic [7:0] ed;
        logic       ev, pop, full, stb;
        ev = fifo_m.size() != 0;
        ed = ev ? fifo_m[0] : 8'h00;
        check("outputs", {12'h0, m_valid, m_data, frame_err, parity_err, overrun, err_count},
              {12'h0, ev, ed, exp_ferr, exp_perr, exp_ovr, exp_cnt[7:0]});
        seen_ferr += int'(frame_err);
        seen_perr += int'(parity_err);
        seen_ovr  += int'(overrun);
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        exp_ovr  = 1'b0;
        if (phase == 0) begin
            if (line_q.size() != 0) cur = line_q.pop_front();
            else begin
                cur.b = 1'b1;
                cur.tag = TagNone;
                cur.data = 8'h00;
            end
        end
        stb = (phase == DIV - 1);
        rx_bit = cur.b;
        baud = stb;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = stb && (cur.tag != TagNone);
        endcase
        full = (fifo_m.size() == DEPTH);
        pop = ev && m_ready;
        if (pop) popped.push_back(fifo_m.pop_front());
        if (stb) begin
            case (cur.tag)
                TagGood: begin
                    if (full && !pop) exp_ovr = 1'b1;
                    else fifo_m.push_back(cur.data);
                end
                TagFerr: begin
                    exp_ferr = 1'b1;
                    if (exp_cnt < 255) exp_cnt++;
                end
                TagPerr: begin
                    exp_perr = 1'b1;
                    if (exp_cnt < 255) exp_cnt++;
                end
                default: ;
            endcase
        end
        phase = (phase + 1) % DIV;
        @(negedge clk);
    endtask

    task automatic run();
        while (line_q.size() != 0 || phase != 0) step();
        repeat (2) step();
    endtask

    task automatic drain(input int max_cycles);
        ready_mode = 1;
        for (int i = 0; i < max_cycles && fifo_m.size() != 0; i++) step();
        step();
    endtask

    task automatic clear_obs();
        popped.delete();
        seen_ferr = 0;
        seen_perr = 0;
        seen_ovr = 0;
    endtask

    task automatic do_reset(input int n, input logic baud_level);
        rst = 1'b1;
        baud = baud_level;
        rx_bit = 1'b1;
        m_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("reset_outputs", {12'h0, m_valid, m_data, frame_err, parity_err, overrun,
                  err_count}, 32'h0);
        end
        fifo_m.delete();
        line_q.delete();
        exp_cnt = 0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        exp_ovr = 1'b0;
        phase = 0;
        cur.b = 1'b1;
        cur.tag = TagNone;
        cur.data = 8'h00;
        rst = 1'b0;
        clear_obs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{data: 8'hA5, stop: 1'b1, n_low: 0, exp_pops: 1, exp_byte: 8'hA5,
                   exp_ferr: 0, exp_cnt: 0};
        tbl[1] = '{data: 8'h3C, stop: 1'b0, n_low: 3, exp_pops: 0, exp_byte: 8'h00,
                   exp_ferr: 1, exp_cnt: 1};
        tbl[2] = '{data: 8'h55, stop: 1'b1, n_low: 0, exp_pops: 1, exp_byte: 8'h55,
                   exp_ferr: 0, exp_cnt: 1};
        tbl[3] = '{data: 8'h00, stop: 1'b1, n_low: 0, exp_pops: 1, exp_byte: 8'h00,
                   exp_ferr: 0, exp_cnt: 1};
        tbl[4] = '{data: 8'hFF, stop: 1'b0, n_low: 0, exp_pops: 0, exp_byte: 8'h00,
                   exp_ferr: 1, exp_cnt: 2};
        tbl[5] = '{data: 8'h80, stop: 1'b1, n_low: 0, exp_pops: 1, exp_byte: 8'h80,
                   exp_ferr: 0, exp_cnt: 2};

        ready_mode = 1;
        do_reset(2, 1'b0);

        // Directed frames, consumer always ready
        for (int i = 0; i < 6; i++) begin
            clear_obs();
            ready_mode = 1;
            queue_frame(tbl[i].data, tbl[i].stop, 1'b0, tbl[i].n_low);
            run();
            drain(20);
            check("tbl_pops", popped.size(), tbl[i].exp_pops);
            check("tbl_byte", (popped.size() != 0) ? popped[0] : 8'h00, tbl[i].exp_byte);
            check("tbl_frame_err", seen_ferr, tbl[i].exp_ferr);
            check("tbl_err_count", err_count, tbl[i].exp_cnt);
        end

        // Five frames into a four-deep FIFO with no consumer
        do_reset(2, 1'b0);
        ready_mode = 0;
        for (int k = 1; k <= 5; k++) queue_frame(8'(k), 1'b1, 1'b0, 0);
        run();
        check("ovr_pulses", seen_ovr, 1);
        drain(20);
        check("ovr_drain_n", popped.size(), 4);
        for (int k = 0; k < 4; k++) check("ovr_order", popped[k], k + 1);

        // Full FIFO, consumer ready exactly on the fifth push
        do_reset(2, 1'b0);
        ready_mode = 0;
        for (int k = 1; k <= 4; k++) queue_frame(8'(k), 1'b1, 1'b0, 0);
        run();
        clear_obs();
        ready_mode = 3;
        queue_frame(8'h05, 1'b1, 1'b0, 0);
        run();
        check("full_pop_no_ovr", seen_ovr, 0);
        check("full_pop_n", popped.size(), 1);
        check("full_pop_first", popped[0], 8'h01);
        drain(20);
        check("full_pop_total", popped.size(), 5);
        for (int k = 0; k < 5; k++) check("full_pop_order", popped[k], k + 1);

        // Reset in the middle of a frame, released with baud already high
        do_reset(2, 1'b0);
        ready_mode = 1;
        queue_frame(8'hFF, 1'b1, 1'b0, 0);
        repeat (5 * DIV) step();
        do_reset(3, 1'b1);
        rx_bit = 1'b0;
        baud = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_quiet", {m_valid, frame_err, overrun, err_count}, 11'h0);
        end
        ready_mode = 1;
        queue_frame(8'h81, 1'b1, 1'b0, 0);
        run();
        drain(20);
        check("rst_only_n", popped.size(), 1);
        check("rst_only_byte", popped[0], 8'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity: correct parity accepted, wrong parity rejected
        do_reset(2, 1'b0);
        ready_mode = 1;
        queue_frame(8'h07, 1'b1, 1'b0, 0);
        run();
        drain(20);
        queue_frame(8'h07, 1'b1, 1'b1, 0);
        run();
        drain(20);
        check("par_n", popped.size(), 1);
        check("par_byte", popped[0], 8'h07);
        check("par_err_pulses", seen_perr, 1);
        check("par_err_count", err_count, 1);
`endif

        // Error counter saturation
        do_reset(2, 1'b0);
        ready_mode = 1;
        for (int k = 0; k < 256; k++) queue_frame(8'($urandom), 1'b0, 1'b0, 0);
        run();
        check("sat_pulses", seen_ferr, 256);
        check("sat_count", err_count, 255);

        // Randomized traffic with random back-pressure
        do_reset(2, 1'b0);
        ready_mode = 2;
        for (int k = 0; k < 80; k++) begin
            queue_frame(8'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                        int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) push_bit(1'b1);
        end
        run();
        drain(40);
        check("rand_drained", m_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
